// File: rtl/bcd_stopwatch_counter.sv
// bcd_stopwatch_counter
// Two-digit BCD seconds counter (00 .. MAX_TENS9) used as the datapath behind
// the stopwatch FSM. A prescaler divides clk into count steps. The units and
// tens digits count up or down and wrap at the ends of the range. A parallel
// load path lets the FSM preset either digit.
//
// Per-edge priority: reset_n low, then clear, then load, then step.
// A step that lands on a load edge is dropped for both digits. The prescaler
// still advances on that edge, so the step cadence stays the same.

module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 4,
    parameter int MAX_TENS = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       up,
    input  logic       load0,
    input  logic [3:0] load0_value,
    input  logic       load1,
    input  logic [3:0] load1_value,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic       tick,
    output logic       wrap
);

    // Prescaler width; a divide-by-1 build still keeps a 1-bit register.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [3:0]    UNITS_MAX  = 4'd9;
    localparam logic [3:0]    TENS_MAX   = 4'(MAX_TENS);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    q0_q, q0_d;
    logic [3:0]    q1_q, q1_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    // Internal step request, and the digit values a step or a load would produce.
    logic          step;
    logic          load_any;
    logic [3:0]    load0_sat;
    logic [3:0]    load1_sat;
    logic [3:0]    step_q0;
    logic [3:0]    step_q1;
    logic          step_wraps;

    // Prescaler: runs while enabled and holds while paused, so a resumed
    // count finishes the partial period. It raises a step on its terminal count.
    always_comb begin
        presc_d = presc_q;
        step    = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                step    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // Saturate load values so out-of-range inputs cannot push a digit out of BCD.
    always_comb begin
        load_any  = load0 | load1;
        load0_sat = (load0_value > UNITS_MAX) ? UNITS_MAX : load0_value;
        load1_sat = (load1_value > TENS_MAX)  ? TENS_MAX  : load1_value;
    end

    // Up/down BCD digit chain. The result is used only when a step is applied.
    always_comb begin
        step_q0    = q0_q;
        step_q1    = q1_q;
        step_wraps = 1'b0;
        if (up) begin
            if (q0_q < UNITS_MAX) begin
                step_q0 = q0_q + 4'd1;
            end else begin
                step_q0 = 4'd0;
                if (q1_q >= TENS_MAX) begin
                    step_q1    = 4'd0;
                    step_wraps = 1'b1;
                end else begin
                    step_q1 = q1_q + 4'd1;
                end
            end
        end else begin
            if (q0_q != 4'd0) begin
                step_q0 = q0_q - 4'd1;
            end else begin
                step_q0 = UNITS_MAX;
                if (q1_q == 4'd0) begin
                    step_q1    = TENS_MAX;
                    step_wraps = 1'b1;
                end else begin
                    step_q1 = q1_q - 4'd1;
                end
            end
        end
    end

    // Choose the digit and pulse next-state: clear first, then load, then step.
    always_comb begin
        q0_d   = q0_q;
        q1_d   = q1_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (clear) begin
            q0_d = 4'd0;
            q1_d = 4'd0;
        end else if (load_any) begin
            if (load0) begin
                q0_d = load0_sat;
            end
            if (load1) begin
                q1_d = load1_sat;
            end
        end else if (step) begin
            q0_d   = step_q0;
            q1_d   = step_q1;
            tick_d = 1'b1;
            wrap_d = step_wraps;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
            q0_q    <= 4'd0;
            q1_q    <= 4'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q0   = q0_q;
    assign q1   = q1_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter (TICK_DIV=4, MAX_TENS=5).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_bcd_stopwatch_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       enable;
    logic       up;
    logic       load0;
    logic [3:0] load0_value;
    logic       load1;
    logic [3:0] load1_value;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       tick;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    bcd_stopwatch_counter #(.TICK_DIV(4), .MAX_TENS(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .enable      (enable),
        .up          (up),
        .load0       (load0),
        .load0_value (load0_value),
        .load1       (load1),
        .load1_value (load1_value),
        .q0          (q0),
        .q1          (q1),
        .tick        (tick),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until tick is seen; n is the number of edges taken.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!tick && cnt < 20);
        if (!tick) chk("tick_timeout", tick, 1);
    endtask

    task automatic set_load(input logic l1, input logic [3:0] v1,
                            input logic l0, input logic [3:0] v0);
        load1 = l1; load1_value = v1;
        load0 = l0; load0_value = v0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; enable = 1'b0; up = 1'b1;
        set_load(1'b0, 4'd0, 1'b0, 4'd0);
        cyc(2);
        chk("rst_q0", q0, 0);
        chk("rst_q1", q1, 0);
        chk("rst_tick", tick, 0);
        chk("rst_wrap", wrap, 0);

        // First step arrives 4 edges after enable.
        reset_n = 1'b1; enable = 1'b1; up = 1'b1;
        wait_tick(n);
        chk("first_lat", n, 4);
        chk("first_q0", q0, 1);
        chk("first_q1", q1, 0);
        wait_tick(n);
        chk("second_lat", n, 4);
        chk("second_q0", q0, 2);

        // Preset 58 and count up through the wrap.
        enable = 1'b0;
        set_load(1'b1, 4'd5, 1'b1, 4'd8);
        cyc(1);
        chk("ld58_q0", q0, 8);
        chk("ld58_q1", q1, 5);
        set_load(1'b0, 4'd0, 1'b0, 4'd0);
        enable = 1'b1; up = 1'b1;
        wait_tick(n);
        chk("up59_q0", q0, 9);
        chk("up59_q1", q1, 5);
        chk("up59_wrap", wrap, 0);
        wait_tick(n);
        chk("up00_q0", q0, 0);
        chk("up00_q1", q1, 0);
        chk("up00_wrap", wrap, 1);
        cyc(1);
        chk("post_wrap", wrap, 0);
        chk("post_tick", tick, 0);

        // Count down from 00 through the wrap.
        up = 1'b0;
        wait_tick(n);
        chk("dn59_q0", q0, 9);
        chk("dn59_q1", q1, 5);
        chk("dn59_wrap", wrap, 1);
        wait_tick(n);
        chk("dn58_q0", q0, 8);
        chk("dn58_wrap", wrap, 0);

        // Out-of-range loads saturate.
        enable = 1'b0;
        set_load(1'b1, 4'd7, 1'b1, 4'd12);
        cyc(1);
        chk("sat_q0", q0, 9);
        chk("sat_q1", q1, 5);

        // Borrow from 10 down to 09.
        set_load(1'b1, 4'd1, 1'b1, 4'd0);
        cyc(1);
        set_load(1'b0, 4'd0, 1'b0, 4'd0);
        enable = 1'b1; up = 1'b0;
        wait_tick(n);
        chk("borrow_q0", q0, 9);
        chk("borrow_q1", q1, 0);

        // Load on the same edge as a prescaler step.
        enable = 1'b0; clear = 1'b1;
        cyc(1);
        clear = 1'b0; enable = 1'b1; up = 1'b1;
        cyc(3);
        chk("pre_coin_tick", tick, 0);
        set_load(1'b1, 4'd1, 1'b1, 4'd4);
        cyc(1);
        chk("coin_q0", q0, 4);
        chk("coin_q1", q1, 1);
        chk("coin_tick", tick, 0);
        set_load(1'b0, 4'd0, 1'b0, 4'd0);
        wait_tick(n);
        chk("coin_next_lat", n, 4);
        chk("coin_next_q0", q0, 5);
        chk("coin_next_q1", q1, 1);

        // A single-digit load leaves the other digit unchanged.
        enable = 1'b0;
        set_load(1'b0, 4'd3, 1'b1, 4'd7);
        cyc(1);
        chk("ld0only_q0", q0, 7);
        chk("ld0only_q1", q1, 1);

        // Counting at 37, then clear together with load0.
        set_load(1'b1, 4'd3, 1'b1, 4'd7);
        cyc(1);
        chk("ld37_q0", q0, 7);
        chk("ld37_q1", q1, 3);
        set_load(1'b0, 4'd0, 1'b0, 4'd0);
        enable = 1'b1;
        cyc(2);
        clear = 1'b1;
        set_load(1'b0, 4'd0, 1'b1, 4'd5);
        cyc(1);
        chk("clr_q0", q0, 0);
        chk("clr_q1", q1, 0);
        chk("clr_tick", tick, 0);
        clear = 1'b0;
        set_load(1'b0, 4'd0, 1'b0, 4'd0);
        wait_tick(n);
        chk("clr_presc_lat", n, 4);
        chk("clr_next_q0", q0, 1);

        // Reset with the counter enabled holds 00 with no ticks.
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("rstrun_tick", tick, 0);
        end
        chk("rstrun_q0", q0, 0);
        chk("rstrun_q1", q1, 0);
        reset_n = 1'b1;
        wait_tick(n);
        chk("rst_resume_lat", n, 4);
        chk("rst_resume_q0", q0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
